// File: rtl/kcpsmx3_inc_pkg.sv
// Shared stack geometry, types and request decode for the KCPSMX call/return stack.
package kcpsmx3_inc;

    localparam int unsigned STACK_DEPTH = 5;
    localparam int unsigned STACK_WIDTH = 10;
    localparam int unsigned STACK_SIZE  = 32'(1) << STACK_DEPTH;

    typedef logic [STACK_DEPTH-1:0] stack_ptr_t;
    typedef logic [STACK_WIDTH-1:0] stack_word_t;

    typedef enum logic [1:0] {
        STK_IDLE    = 2'd0,
        STK_PUSH    = 2'd1,
        STK_POP     = 2'd2,
        STK_REPLACE = 2'd3
    } stack_op_t;

    // A stalled pipeline issues no stack operation at all
    function automatic stack_op_t decode_op(input logic push, input logic pop, input logic stall);
        stack_op_t op;
        op = STK_IDLE;
        if (!stall) begin
            case ({push, pop})
                2'b10:   op = STK_PUSH;
                2'b01:   op = STK_POP;
                2'b11:   op = STK_REPLACE;
                default: op = STK_IDLE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/kcpsmx_stack_ctrl.sv
// Call/return stack controller: owns stack pointer and occupancy, drives the stack RAM port
// and returns a registered return address one cycle after a pop.
// Optional sticky overflow/underflow flags and err_clear: define KCPSMX_STACK_ERR_EN.
module kcpsmx_stack_ctrl #(
    parameter int unsigned STACK_DEPTH = kcpsmx3_inc::STACK_DEPTH,
    parameter int unsigned STACK_WIDTH = kcpsmx3_inc::STACK_WIDTH,
    parameter int unsigned STACK_SIZE  = kcpsmx3_inc::STACK_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   push,
    input  logic                   pop,
    input  logic [STACK_WIDTH-1:0] push_data,
    output logic [STACK_WIDTH-1:0] ret_addr,
    output logic                   ret_valid,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic [STACK_DEPTH-1:0] ram_address,
    output logic                   ram_write_enable,
    output logic [STACK_WIDTH-1:0] ram_data_in,
    input  logic [STACK_WIDTH-1:0] ram_data_out
`ifdef KCPSMX_STACK_ERR_EN
    ,
    input  logic                   err_clear,
    output logic                   stack_overflow,
    output logic                   stack_underflow
`endif
);

    import kcpsmx3_inc::*;

    localparam int unsigned CNT_W = STACK_DEPTH + 1;
    localparam logic [STACK_DEPTH-1:0] PTR_ONE  = STACK_DEPTH'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(STACK_SIZE);

    logic [STACK_DEPTH-1:0] sp_q, sp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STACK_WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic                   ret_valid_q, ret_valid_d;

    stack_op_t              op_c;
    logic                   empty_c;
    logic                   full_c;
    logic [STACK_DEPTH-1:0] sp_dec_c;

    // Operation decode and occupancy status
    always_comb begin
        op_c     = decode_op(push, pop, stall);
        empty_c  = (cnt_q == '0);
        full_c   = (cnt_q == CNT_FULL);
        sp_dec_c = sp_q - PTR_ONE;
    end

    // State register; reset leaves RAM contents alone and drops any pending return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q        <= '0;
            cnt_q       <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    // Next-state: pointer wraps freely, count saturates at both ends
    always_comb begin
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        case (op_c)
            STK_IDLE: begin
            end
            STK_PUSH: begin
                sp_d = sp_q + PTR_ONE;
                if (!full_c) cnt_d = cnt_q + CNT_ONE;
            end
            STK_POP: begin
                sp_d        = sp_dec_c;
                ret_addr_d  = ram_data_out;
                ret_valid_d = 1'b1;
                if (!empty_c) cnt_d = cnt_q - CNT_ONE;
            end
            STK_REPLACE: begin
                // Replacing the top of an empty stack degenerates into a plain push
                if (empty_c) begin
                    sp_d  = sp_q + PTR_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    ret_addr_d  = ram_data_out;
                    ret_valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // RAM-side drive: reads of the top use sp-1, the async read precedes the clocked write
    always_comb begin
        ram_address      = sp_q;
        ram_write_enable = 1'b0;
        ram_data_in      = push_data;
        case (op_c)
            STK_PUSH:    ram_write_enable = 1'b1;
            STK_POP:     ram_address      = sp_dec_c;
            STK_REPLACE: begin
                ram_write_enable = 1'b1;
                if (!empty_c) ram_address = sp_dec_c;
            end
            default: begin
            end
        endcase
    end

    assign ret_addr    = ret_addr_q;
    assign ret_valid   = ret_valid_q;
    assign stack_empty = empty_c;
    assign stack_full  = full_c;

`ifdef KCPSMX_STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error flags; a set event outranks a simultaneous clear
    always_comb begin
        ovf_d = (ovf_q & ~err_clear) | ((op_c == STK_PUSH) & full_c);
        unf_d = (unf_q & ~err_clear) | (((op_c == STK_POP) | (op_c == STK_REPLACE)) & empty_c);
    end

    // Error flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
`endif

endmodule
